// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router read scheduler.
//   state_t     - read-scheduler FSM states
//   NUM_PORTS   - number of source FIFOs
//   LEN_W       - width of the header length field
//   HDR_LEN_*   - bit positions of the length field in the header byte
//   oh2idx()    - one-hot grant to port index
package router_pkg;

    localparam int unsigned NUM_PORTS   = 3;
    localparam int unsigned LEN_W       = 6;
    localparam int unsigned HDR_LEN_LSB = 2;
    localparam int unsigned HDR_LEN_MSB = HDR_LEN_LSB + LEN_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic logic [1:0] oh2idx(input logic [NUM_PORTS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/router_rd_sched_if.sv
// router_rd_sched_if: downstream byte stream of the read scheduler.
//   o_data/o_valid/o_ready - byte handshake (o_ready driven by the sink)
//   o_sop/o_eop            - header / parity byte markers
//   o_port                 - source FIFO of the current packet
//   o_abort/busy           - stall-abort pulse, packet in progress
//   o_perr                 - parity error with the eop byte (ROUTER_PARITY_CHK_EN only)
interface router_rd_sched_if;

    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready;
    logic       o_sop;
    logic       o_eop;
    logic [1:0] o_port;
    logic       o_abort;
    logic       busy;
`ifdef ROUTER_PARITY_CHK_EN
    logic       o_perr;

    modport master (output o_data, o_valid, o_sop, o_eop, o_port, o_abort, busy, o_perr,
                    input  o_ready);
    modport slave  (input  o_data, o_valid, o_sop, o_eop, o_port, o_abort, busy, o_perr,
                    output o_ready);
`else
    modport master (output o_data, o_valid, o_sop, o_eop, o_port, o_abort, busy,
                    input  o_ready);
    modport slave  (input  o_data, o_valid, o_sop, o_eop, o_port, o_abort, busy,
                    output o_ready);
`endif

endinterface

// File: rtl/router_rd_sched_rr_arb3.sv
// rr_arb3: 3-way round-robin arbiter.
//   req_i  - request per port
//   last_i - last granted port; search starts at the port after it
//   gnt_o  - one-hot grant (all zero when nothing requests)
module rr_arb3
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [1:0]           last_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        case (last_i)
            2'd0: begin
                if      (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
            end
            2'd1: begin
                if      (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
            end
            default: begin
                if      (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/router_rd_sched.sv
// router_rd_sched: reads whole packets from three byte FIFOs, one byte per
// ISSUE/LATCH/HOLD round, and presents them downstream with sop/eop marks.
//   clk, rst             - clock, asynchronous active-low reset
//   vld_out_n / dout_n   - FIFO n not-empty / read data (one cycle after rd_en_n)
//   rd_en_n              - FIFO n read strobe
//   dn (master modport)  - downstream byte stream, see router_rd_sched_if
// Optional build macro: ROUTER_PARITY_CHK_EN adds the o_perr parity check.
module router_rd_sched
    import router_pkg::*;
#(
    parameter int unsigned STALL_MAX = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] dout_0,
    input  logic [7:0] dout_1,
    input  logic [7:0] dout_2,
    output logic       rd_en_0,
    output logic       rd_en_1,
    output logic       rd_en_2,
    router_rd_sched_if.master dn
);

    localparam int unsigned   STALL_W = $clog2(STALL_MAX + 1);
    localparam logic [LEN_W:0] REM_ONE = 1;

    state_t               state_q, state_d;
    logic [1:0]           port_q, port_d;
    logic [1:0]           last_q, last_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [LEN_W:0]       rem_q, rem_d;
    logic                 first_q, first_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic                 abort_q, abort_d;

    logic [NUM_PORTS-1:0] req, gnt;
    logic                 vsel, issue_rd;
    logic [7:0]           dsel;

    assign req = {vld_out_2, vld_out_1, vld_out_0};

    rr_arb3 u_arb (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    always_comb begin
        case (port_q)
            2'd0:    begin vsel = vld_out_0; dsel = dout_0; end
            2'd1:    begin vsel = vld_out_1; dsel = dout_1; end
            default: begin vsel = vld_out_2; dsel = dout_2; end
        endcase
    end

    assign issue_rd = (state_q == ISSUE) && vsel;
    assign rd_en_0  = issue_rd && (port_q == 2'd0);
    assign rd_en_1  = issue_rd && (port_q == 2'd1);
    assign rd_en_2  = issue_rd && (port_q == 2'd2);

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        stall_d = stall_q;
        rem_d   = rem_q;
        first_d = first_q;
        data_d  = data_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    port_d  = oh2idx(gnt);
                    last_d  = oh2idx(gnt);
                    first_d = 1'b1;
                    stall_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (vsel) begin
                    stall_d = '0;
                    state_d = LATCH;
                end else if (stall_q == STALL_W'(STALL_MAX - 1)) begin
                    abort_d = 1'b1;
                    stall_d = '0;
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            LATCH: begin
                data_d  = dsel;
                valid_d = 1'b1;
                if (first_q) begin
                    // Remaining bytes after the header: payload plus parity.
                    sop_d   = 1'b1;
                    eop_d   = 1'b0;
                    rem_d   = {1'b0, dsel[HDR_LEN_MSB:HDR_LEN_LSB]} + REM_ONE;
                    first_d = 1'b0;
                end else begin
                    sop_d = 1'b0;
                    eop_d = (rem_q == REM_ONE);
                    rem_d = rem_q - REM_ONE;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (dn.o_ready) begin
                    valid_d = 1'b0;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    state_d = eop_q ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            port_q  <= 2'd0;
            last_q  <= 2'd2;
            stall_q <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            stall_q <= stall_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            abort_q <= abort_d;
        end
    end

    assign dn.o_data  = data_q;
    assign dn.o_valid = valid_q;
    assign dn.o_sop   = sop_q;
    assign dn.o_eop   = eop_q;
    assign dn.o_port  = port_q;
    assign dn.o_abort = abort_q;
    assign dn.busy    = (state_q != IDLE);

`ifdef ROUTER_PARITY_CHK_EN
    logic [7:0] par_q, par_d;
    logic       perr_q, perr_d;

    // Running XOR of header and payload; compared against the final byte.
    always_comb begin
        par_d  = par_q;
        perr_d = perr_q;
        if (state_q == LATCH) begin
            if (first_q) begin
                par_d  = dsel;
                perr_d = 1'b0;
            end else if (rem_q == REM_ONE) begin
                perr_d = (par_q != dsel);
            end else begin
                par_d  = par_q ^ dsel;
                perr_d = 1'b0;
            end
        end else if ((state_q == HOLD) && dn.o_ready) begin
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign dn.o_perr = perr_q;
`endif

endmodule

// File: tb/tb_router_rd_sched.sv
`timescale 1ns/1ps
module tb_router_rd_sched;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       perr;
        logic [1:0] port;
    } rec_t;

    logic       clk;
    logic       rst;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic [7:0] dout_0, dout_1, dout_2;
    logic       rd_en_0, rd_en_1, rd_en_2;

    router_rd_sched_if dn ();

    router_rd_sched #(.STALL_MAX(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .vld_out_0 (vld_out_0),
        .vld_out_1 (vld_out_1),
        .vld_out_2 (vld_out_2),
        .dout_0    (dout_0),
        .dout_1    (dout_1),
        .dout_2    (dout_2),
        .rd_en_0   (rd_en_0),
        .rd_en_1   (rd_en_1),
        .rd_en_2   (rd_en_2),
        .dn        (dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    int unsigned rd_cnt0 = 0, rd_cnt1 = 0, rd_cnt2 = 0;
    int unsigned abort_cnt = 0, abort_cyc = 0, last_acc_cyc = 0, viol = 0;
    logic [2:0]  rd_lat = 3'b000;

    logic [7:0]  q0[$], q1[$], q2[$];
    rec_t        rec_q[$], exp_q[$];
    int unsigned rec_cyc[$];

    always @(posedge clk) cyc++;

    // Output / strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        rec_t r;
        rd_lat = {rd_en_2, rd_en_1, rd_en_0};
        if (rd_en_0) rd_cnt0++;
        if (rd_en_1) rd_cnt1++;
        if (rd_en_2) rd_cnt2++;
        if (($countones(rd_lat) > 1) || ((rd_lat != 3'b000) && !dn.busy)) viol++;
        if (dn.o_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (dn.o_valid && dn.o_ready) begin
            r.d    = dn.o_data;
            r.sop  = dn.o_sop;
            r.eop  = dn.o_eop;
`ifdef ROUTER_PARITY_CHK_EN
            r.perr = dn.o_perr;
`else
            r.perr = 1'b0;
`endif
            r.port = dn.o_port;
            rec_q.push_back(r);
            rec_cyc.push_back(cyc);
            last_acc_cyc = cyc;
        end
    end

    function automatic void upd_vld();
        vld_out_0 = (q0.size() != 0);
        vld_out_1 = (q1.size() != 0);
        vld_out_2 = (q2.size() != 0);
    endfunction

    // FIFO model: data appears shortly after the edge that consumed rd_en.
    always @(posedge clk) begin
        #1;
        if (rd_lat[0] && (q0.size() != 0)) dout_0 = q0.pop_front();
        if (rd_lat[1] && (q1.size() != 0)) dout_1 = q1.pop_front();
        if (rd_lat[2] && (q2.size() != 0)) dout_2 = q2.pop_front();
        upd_vld();
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_byte(input int unsigned port, input logic [7:0] b);
        case (port)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    // Builds header/payload/parity; only the first nb bytes reach the FIFO.
    task automatic push_pkt(input int unsigned port, input int unsigned len,
                            input logic [7:0] base, input logic [7:0] flip,
                            input int unsigned nb);
        logic [7:0]  b, x;
        rec_t        r;
        int unsigned total;
        total = len + 2;
        x = 8'h00;
        for (int unsigned i = 0; i < total; i++) begin
            if (i == 0)               b = {len[5:0], base[1:0]};
            else if (i == total - 1)  b = x ^ flip;
            else                      b = base + 8'(i * 7);
            if (i != total - 1) x = x ^ b;
            if (i < nb) begin
                push_byte(port, b);
                r.d    = b;
                r.sop  = (i == 0);
                r.eop  = (i == total - 1);
                r.perr = (i == total - 1) && (flip != 8'h00);
                r.port = port[1:0];
                exp_q.push_back(r);
            end
        end
        upd_vld();
    endtask

    task automatic push_full(input int unsigned port, input int unsigned len,
                             input logic [7:0] base, input logic [7:0] flip);
        push_pkt(port, len, base, flip, len + 2);
    endtask

    task automatic compare_out(input string tag);
        int unsigned n;
        check_vec({tag, " nbytes"}, rec_q.size(), exp_q.size());
        n = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check_vec($sformatf("%s b%0d data", tag, i), rec_q[i].d,    exp_q[i].d);
            check_vec($sformatf("%s b%0d sop", tag, i),  rec_q[i].sop,  exp_q[i].sop);
            check_vec($sformatf("%s b%0d eop", tag, i),  rec_q[i].eop,  exp_q[i].eop);
            check_vec($sformatf("%s b%0d port", tag, i), rec_q[i].port, exp_q[i].port);
`ifdef ROUTER_PARITY_CHK_EN
            check_vec($sformatf("%s b%0d perr", tag, i), rec_q[i].perr, exp_q[i].perr);
`endif
        end
        rec_q.delete();
        exp_q.delete();
        rec_cyc.delete();
    endtask

    task automatic wait_drain(input string tag, input int unsigned maxc);
        int unsigned n;
        n = 0;
        while (((q0.size() + q1.size() + q2.size()) != 0 || dn.busy) && (n < maxc)) begin
            tick(1);
            n++;
        end
        check_vec({tag, " drained"}, (n < maxc), 1);
    endtask

    task automatic check_zero(input string tag);
        check_vec({tag, " o_valid"}, dn.o_valid, 0);
        check_vec({tag, " o_data"},  dn.o_data,  0);
        check_vec({tag, " o_sop"},   dn.o_sop,   0);
        check_vec({tag, " o_eop"},   dn.o_eop,   0);
        check_vec({tag, " o_port"},  dn.o_port,  0);
        check_vec({tag, " o_abort"}, dn.o_abort, 0);
        check_vec({tag, " busy"},    dn.busy,    0);
        check_vec({tag, " rd_en"},   {rd_en_2, rd_en_1, rd_en_0}, 0);
`ifdef ROUTER_PARITY_CHK_EN
        check_vec({tag, " o_perr"},  dn.o_perr,  0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n, a0, base_rd;
        logic [9:0]  snap;
        logic        stable;

        rst = 1'b0;
        dn.o_ready = 1'b1;
        dout_0 = 8'h00;
        dout_1 = 8'h00;
        dout_2 = 8'h00;
        upd_vld();
        tick(3);
        check_zero("reset");

        // Round robin from reset: all three ports ready, two packets each.
        push_full(0, 2, 8'h10, 8'h00);
        push_full(1, 3, 8'h20, 8'h00);
        push_full(2, 1, 8'h30, 8'h00);
        push_full(0, 0, 8'h40, 8'h00);
        push_full(1, 5, 8'h50, 8'h00);
        push_full(2, 2, 8'h60, 8'h00);
        tick(1);
        rst = 1'b1;
        wait_drain("rr", 2000);
        compare_out("rr");

        // Single len=4 packet on port 1 at full rate.
        base_rd = rd_cnt1;
        push_full(1, 4, 8'hA0, 8'h00);
        wait_drain("len4", 500);
        check_vec("len4 rd_en_1 pulses", rd_cnt1 - base_rd, 6);
        for (int unsigned i = 1; i < rec_cyc.size(); i++)
            check_vec($sformatf("len4 gap%0d", i), rec_cyc[i] - rec_cyc[i-1], 3);
        compare_out("len4");

        // Backpressure for 10 cycles mid-payload.
        push_full(0, 6, 8'h11, 8'h00);
        n = 0;
        while ((rec_q.size() < 2) && (n < 200)) begin
            tick(1);
            n++;
        end
        check_vec("bp reach", (n < 200), 1);
        dn.o_ready = 1'b0;
        tick(4);
        check_vec("bp valid held", dn.o_valid, 1);
        snap    = {dn.o_sop, dn.o_eop, dn.o_data};
        base_rd = rd_cnt0 + rd_cnt1 + rd_cnt2;
        stable  = 1'b1;
        repeat (10) begin
            tick(1);
            if (({dn.o_sop, dn.o_eop, dn.o_data} != snap) || !dn.o_valid) stable = 1'b0;
        end
        check_vec("bp stable", stable, 1);
        check_vec("bp no rd_en", rd_cnt0 + rd_cnt1 + rd_cnt2, base_rd);
        check_vec("bp no accept", rec_q.size(), 2);
        dn.o_ready = 1'b1;
        wait_drain("bp", 500);
        compare_out("bp");

        // len=0 packet with a corrupted parity byte (0x25 vs computed 0x00).
        push_full(2, 0, 8'h00, 8'h25);
        wait_drain("len0", 200);
        compare_out("len0");

        // Port 2 runs dry after 3 of 8 payload bytes.
        a0 = abort_cnt;
        push_pkt(2, 8, 8'h70, 8'h00, 4);
        n = 0;
        while ((abort_cnt == a0) && (n < 300)) begin
            tick(1);
            n++;
        end
        check_vec("stall abort seen", (n < 300), 1);
        check_vec("stall busy", dn.busy, 0);
        check_vec("stall timing", abort_cyc - last_acc_cyc, 33);
        tick(3);
        check_vec("stall pulse", abort_cnt - a0, 1);
        compare_out("stall");
        push_full(0, 1, 8'h80, 8'h00);
        push_full(2, 1, 8'h90, 8'h00);
        wait_drain("after abort", 300);
        compare_out("after abort");

        // Reset while a byte is held.
        dn.o_ready = 1'b0;
        push_full(1, 5, 8'hC0, 8'h00);
        tick(6);
        check_vec("hold pre valid", dn.o_valid, 1);
        a0 = abort_cnt;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_zero("hold reset");
        q0.delete();
        q1.delete();
        q2.delete();
        upd_vld();
        exp_q.delete();
        check_vec("hold reset no accept", rec_q.size(), 0);
        tick(2);
        check_vec("hold reset no abort", abort_cnt - a0, 0);
        rst = 1'b1;
        dn.o_ready = 1'b1;
        push_full(0, 1, 8'hD0, 8'h00);
        push_full(1, 2, 8'hE0, 8'h00);
        push_full(2, 0, 8'hF1, 8'h00);
        wait_drain("post reset", 300);
        compare_out("post reset");

        check_vec("rd_en exclusive", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
